biker_spawn_scheduler: RTL and testbench
========================================

Name: biker_spawn_scheduler

Overview:
Level-level sequencer for the pool of biker FSMs. At each level start it decides how many bikers take part and drives each biker's enable. It then releases them one at a time at a level-dependent interval, tracks hits, and reports when the level's bikers are all gone. It sits between the game-level controller and the NUM_BIKERS biker FSM instances, and owns their enabled/startMovement inputs.

Parameters:
NUM_BIKERS, 8, number of biker instances driven (max 15).
BASE_COUNT, 2, bikers at level 0.
SPAWN_INTERVAL_BASE, 20, tenths of a second between releases at level 0.
INTERVAL_LEVEL_STEP, 1, interval reduction per level (tenths).
MIN_INTERVAL, 5, floor on interval (tenths, >=1).

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfLevel  in  1  one-cycle pulse, new level begins
level  in  4  current level, sampled on startOfLevel
oneTensSec  in  1  one-cycle tick every 0.1 s
bikerHit  in  NUM_BIKERS  per-biker one-cycle hit pulse
bikerEnabled  out  NUM_BIKERS  level enable to biker i
bikerStartMovement  out  NUM_BIKERS  one-cycle release pulse to biker i
levelCleared  out  1  one-cycle pulse when all bikers of the level are gone
aliveCount  out  4  number of bikerEnabled bits set
busy  out  1  high from startOfLevel until levelCleared

Behaviour:
- Reset (resetN low at a clk edge): state IDLE. All outputs 0: bikerEnabled, bikerStartMovement, levelCleared, aliveCount, busy. Internal pointer and timer are also 0. Reset mid-level abandons the level; no levelCleared is issued.
- Latched on startOfLevel:
  - quota = min(BASE_COUNT + level/2, NUM_BIKERS), with level/2 truncating.
  - interval = max(SPAWN_INTERVAL_BASE - level*INTERVAL_LEVEL_STEP, MIN_INTERVAL), computed signed and at least 8 bits wide.
- States:
  - IDLE: outputs quiescent. On startOfLevel: latch quota/interval, set bikerEnabled[quota-1:0]=1 in the same cycle, ptr=0, busy=1, go ARM.
  - ARM: exactly one cycle. Lets the bikers see enabled plus startOfLevel and load their coordinates. Go RELEASE.
  - RELEASE: one cycle. If bikerEnabled[ptr], pulse bikerStartMovement[ptr]. Then ptr++ and load timer=interval. If ptr (after increment) == quota, go DRAIN; else go WAIT.
  - WAIT: timer decrements on each oneTensSec. When it reaches 0 on a tick, go RELEASE. Release spacing is therefore interval ticks (+1 clk).
  - DRAIN: wait until bikerEnabled == 0, then go DONE.
  - DONE: one cycle. levelCleared=1, busy=0, go IDLE.
- Hits, in any non-IDLE state: bikerHit[i] clears bikerEnabled[i] on the next edge. A hit on a bit already 0, or on i >= quota, is ignored. A biker hit before its release is never given a startMovement pulse, and its release slot is still consumed (timing is unchanged).
- Hit and release on the same index in the same cycle: the release pulse is suppressed and the bit clears.
- aliveCount: registered popcount of bikerEnabled, updated the cycle after the bit changes.
- startOfLevel in any non-IDLE state restarts the sequence as from IDLE: re-latch, re-enable the quota, ptr=0, no levelCleared. A startOfLevel coinciding with a bikerHit takes priority; the enable vector is reloaded.
- All bikers hit while still in WAIT: keep releasing on schedule with suppressed pulses until ptr==quota, then DRAIN → DONE immediately.
- bikerStartMovement is never asserted for more than one cycle, nor on more than one bit at a time.

Optional Feature:
SCHED_PAUSE_EN:
- Defined: adds input port pause (1 bit). While pause=1, oneTensSec is ignored (the WAIT timer freezes), RELEASE is not entered, and hits are still processed.
- Undefined: no pause port; the timer always counts.

Test Plan:
- Reset then level=0 startOfLevel → bikerEnabled=8'b00000011 next cycle. Release on biker0 2 clks after the pulse, biker1 20 ticks later. busy=1, aliveCount=2.
- level=6 → quota=5, interval=14. Five single-bit releases (bits 0..4) spaced 14 ticks, no pulse on bits 5..7.
- level=15 → quota=min(9,8)=8, interval=max(5,5)=5. Hit all 8 after the last release → levelCleared one-cycle pulse, busy=0, aliveCount=0.
- level=4: hit biker2 before its release → bit clears, no pulse on bit 2. Biker3 is still released at its original slot.
- Mid-WAIT startOfLevel with level=2 → enables reset to 3'b111, ptr=0, no levelCleared. resetN low mid-DRAIN → all outputs 0 next edge.
- With SCHED_PAUSE_EN, level=0: pause=1 for 30 ticks during WAIT → biker1 release delayed by exactly 30 ticks.

Source files
------------

// File: rtl/biker_spawn_scheduler.sv
// biker_spawn_scheduler
// Per-level sequencer for the biker FSM pool: enables the level's quota of
// bikers, releases them one at a time at a level-dependent interval, clears
// enables on hits and reports when every biker of the level is gone.
// Optional feature macro: SCHED_PAUSE_EN adds a pause input that freezes the
// release timer and holds off releases while hits keep being processed.
module biker_spawn_scheduler #(
    parameter int NUM_BIKERS          = 8,
    parameter int BASE_COUNT          = 2,
    parameter int SPAWN_INTERVAL_BASE = 20,
    parameter int INTERVAL_LEVEL_STEP = 1,
    parameter int MIN_INTERVAL        = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfLevel,
    input  logic [3:0]            level,
    input  logic                  oneTensSec,
`ifdef SCHED_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [NUM_BIKERS-1:0] bikerHit,
    output logic [NUM_BIKERS-1:0] bikerEnabled,
    output logic [NUM_BIKERS-1:0] bikerStartMovement,
    output logic                  levelCleared,
    output logic [3:0]            aliveCount,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RELEASE = 3'd2,
        WAIT    = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } stateT;

    stateT                  state;
    stateT                  nextState;
    logic [3:0]             ptr;
    logic [3:0]             quota;
    logic [7:0]             interval;
    logic [7:0]             timer;
    logic [4:0]             quotaRaw;
    logic signed [9:0]      intervalRaw;
    logic [3:0]             newQuota;
    logic [7:0]             newInterval;
    logic [NUM_BIKERS-1:0]  enableMask;
    logic [3:0]             aliveNext;
    logic                   paused;
    logic                   tick;

`ifdef SCHED_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign tick = oneTensSec & ~paused;

    // Level-derived quota, interval and enable mask, latched on startOfLevel.
    always_comb begin
        quotaRaw    = 5'(BASE_COUNT) + {2'b00, level[3:1]};
        newQuota    = (quotaRaw > 5'(NUM_BIKERS)) ? 4'(NUM_BIKERS) : 4'(quotaRaw);
        // Signed so that high levels go negative before the floor is applied.
        intervalRaw = 10'(SPAWN_INTERVAL_BASE)
                    - $signed({6'd0, level}) * 10'(INTERVAL_LEVEL_STEP);
        newInterval = (intervalRaw < 10'(MIN_INTERVAL)) ? 8'(MIN_INTERVAL)
                                                        : 8'(intervalRaw);
        for (int i = 0; i < NUM_BIKERS; i++) begin
            enableMask[i] = (i < int'(newQuota));
        end
    end

    // Population count of the enable vector, registered into aliveCount.
    always_comb begin
        aliveNext = '0;
        for (int i = 0; i < NUM_BIKERS; i++) begin
            aliveNext = aliveNext + 4'(bikerEnabled[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        nextState          = state;
        bikerStartMovement = '0;
        levelCleared       = 1'b0;
        busy               = 1'b0;
        case (state)
            IDLE: begin
                nextState = IDLE;
            end
            ARM: begin
                busy = 1'b1;
                if (!paused) begin
                    nextState = RELEASE;
                end
            end
            RELEASE: begin
                busy = 1'b1;
                // A hit or restart in the release cycle wins over the pulse.
                for (int i = 0; i < NUM_BIKERS; i++) begin
                    if (ptr == 4'(i) && bikerEnabled[i] && !bikerHit[i] && !startOfLevel) begin
                        bikerStartMovement[i] = 1'b1;
                    end
                end
                nextState = ((ptr + 4'd1) >= quota) ? DRAIN : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (tick && timer <= 8'd1) begin
                    nextState = RELEASE;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (bikerEnabled == '0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                levelCleared = 1'b1;
                nextState    = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (startOfLevel) begin
            nextState = ARM;
        end
    end

    // Enables, release pointer, interval timer and alive counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here samples the pre-edge values of the others.
        if (!resetN) begin
            bikerEnabled <= '0;
            aliveCount   <= '0;
            ptr          <= '0;
            timer        <= '0;
            quota        <= '0;
            interval     <= '0;
        end else begin
            aliveCount <= aliveNext;
            if (startOfLevel) begin
                quota        <= newQuota;
                interval     <= newInterval;
                bikerEnabled <= enableMask;
                ptr          <= '0;
                timer        <= '0;
            end else begin
                if (state != IDLE) begin
                    bikerEnabled <= bikerEnabled & ~bikerHit;
                end
                if (state == RELEASE) begin
                    ptr   <= ptr + 4'd1;
                    timer <= interval;
                end else if (state == WAIT && tick) begin
                    timer <= timer - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_biker_spawn_scheduler.sv
// tb_biker_spawn_scheduler
// Directed level scenarios with randomized tick and hit patterns. Expected
// outputs come from a release schedule derived from the level rules: release
// k happens the cycle after the interval-th unpaused tick following release
// k-1, enables fall the cycle after a hit, and the level clears the cycle
// after the enables are empty once the last release has gone out.
module tb_biker_spawn_scheduler;

    localparam int NB    = 8;
    localparam int BASE  = 2;
    localparam int IBASE = 20;
    localparam int ISTEP = 1;
    localparam int IMIN  = 5;
    localparam int MAXC  = 1200;

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfLevel;
    logic [3:0]    level;
    logic          oneTensSec;
`ifdef SCHED_PAUSE_EN
    logic          pause;
`endif
    logic [NB-1:0] bikerHit;
    logic [NB-1:0] bikerEnabled;
    logic [NB-1:0] bikerStartMovement;
    logic          levelCleared;
    logic [3:0]    aliveCount;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic          tickArr  [MAXC];
    logic          pauseArr [MAXC];
    logic [NB-1:0] hitArr   [MAXC];
    int            relCyc   [NB];
    int            obsRel   [NB];
    int            qExp;
    int            iExp;
    logic [NB-1:0] enCarry;

    biker_spawn_scheduler #(
        .NUM_BIKERS(NB), .BASE_COUNT(BASE), .SPAWN_INTERVAL_BASE(IBASE),
        .INTERVAL_LEVEL_STEP(ISTEP), .MIN_INTERVAL(IMIN)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfLevel(startOfLevel),
        .level(level),
        .oneTensSec(oneTensSec),
`ifdef SCHED_PAUSE_EN
        .pause(pause),
`endif
        .bikerHit(bikerHit),
        .bikerEnabled(bikerEnabled),
        .bikerStartMovement(bikerStartMovement),
        .levelCleared(levelCleared),
        .aliveCount(aliveCount),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    // Fresh tick pattern with at most density-1 idle cycles between ticks.
    task automatic genStim(input int density);
        int gap = 0;
        for (int c = 0; c < MAXC; c++) begin
            tickArr[c]  = ($urandom_range(density - 1, 0) == 0) || (gap >= density - 1);
            gap         = tickArr[c] ? 0 : gap + 1;
            pauseArr[c] = 1'b0;
            hitArr[c]   = '0;
        end
    endtask

    // Quota, interval and release cycles from the level rules.
    task automatic computeReleases(input int lvl);
        int t;
        int cnt;
        qExp = BASE + lvl / 2;
        if (qExp > NB) qExp = NB;
        iExp = IBASE - lvl * ISTEP;
        if (iExp < IMIN) iExp = IMIN;
        t = 1;
        while (t < MAXC && pauseArr[t]) t++;
        relCyc[0] = t + 1;
        for (int k = 1; k < NB; k++) relCyc[k] = MAXC;
        for (int k = 1; k < qExp; k++) begin
            cnt = 0;
            t   = relCyc[k-1] + 1;
            while (t < MAXC) begin
                if (tickArr[t] && !pauseArr[t]) begin
                    cnt++;
                    if (cnt == iExp) break;
                end
                t++;
            end
            relCyc[k] = t + 1;
        end
    endtask

    task automatic sparseHits(input int every);
        for (int c = 0; c < MAXC; c++) begin
            if ($urandom_range(every - 1, 0) == 0) hitArr[c][$urandom_range(NB - 1, 0)] = 1'b1;
        end
    endtask

    // Hit every biker k cycles after the last release.
    task automatic endHit(input int k);
        int c = relCyc[qExp-1] + k;
        if (c < MAXC) hitArr[c] = '1;
    endtask

    task automatic runScenario(input int lvl, input bit fromIdle, input int abortAt,
                               input logic [NB-1:0] prevEn, output logic [NB-1:0] enOut);
        logic [NB-1:0] en;
        logic [NB-1:0] enNext;
        logic [NB-1:0] mask;
        logic [NB-1:0] expStart;
        int            clrCyc;
        int            lastRel;
        int            endCyc;
        int            aliveExp;
        bit            aliveKnown;
        bit            busyExp;
        mask = '0;
        for (int i = 0; i < qExp; i++) mask[i] = 1'b1;
        en         = prevEn;
        clrCyc     = -1;
        lastRel    = relCyc[qExp-1];
        aliveExp   = 0;
        aliveKnown = fromIdle;
        for (int k = 0; k < NB; k++) obsRel[k] = -1;
        endCyc = (abortAt > 0) ? abortAt : MAXC - 1;
        for (int c = 0; c < endCyc; c++) begin
            @(posedge clk);
            #1;
            startOfLevel = (c == 0);
            level        = 4'(lvl);
            oneTensSec   = tickArr[c];
            bikerHit     = hitArr[c];
`ifdef SCHED_PAUSE_EN
            pause        = pauseArr[c];
`endif
            if (c > lastRel && clrCyc < 0 && en == '0) clrCyc = c + 1;
            expStart = '0;
            for (int k = 0; k < qExp; k++) begin
                if (c == relCyc[k] && en[k] && !hitArr[c][k]) expStart[k] = 1'b1;
            end
            busyExp = (c == 0) ? !fromIdle : (clrCyc < 0 || c < clrCyc);
            @(negedge clk);
            for (int k = 0; k < NB; k++) begin
                if (bikerStartMovement[k] && obsRel[k] < 0) obsRel[k] = c;
            end
            check($sformatf("L%0d startMovement", lvl), c, 32'(bikerStartMovement), 32'(expStart));
            check($sformatf("L%0d enabled", lvl), c, 32'(bikerEnabled), 32'(en));
            if (aliveKnown) check($sformatf("L%0d aliveCount", lvl), c, 32'(aliveCount), 32'(aliveExp));
            check($sformatf("L%0d levelCleared", lvl), c, 32'(levelCleared), 32'(c == clrCyc));
            check($sformatf("L%0d busy", lvl), c, 32'(busy), 32'(busyExp));
            if (c == 0) enNext = mask;
            else if (clrCyc < 0 || c < clrCyc) enNext = en & ~hitArr[c];
            else enNext = en;
            aliveExp   = $countones(en);
            aliveKnown = 1'b1;
            en         = enNext;
            if (abortAt == 0 && clrCyc >= 0 && c >= clrCyc + 2) break;
        end
        if (abortAt == 0) check($sformatf("L%0d clear_seen", lvl), 0, 32'(clrCyc >= 0), 32'd1);
        enOut = en;
    endtask

    initial begin
        int lvl;
        resetN       = 1'b0;
        startOfLevel = 1'b0;
        level        = '0;
        oneTensSec   = 1'b0;
        bikerHit     = '0;
`ifdef SCHED_PAUSE_EN
        pause        = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset enabled", 0, 32'(bikerEnabled), 0);
        check("reset startMovement", 0, 32'(bikerStartMovement), 0);
        check("reset levelCleared", 0, 32'(levelCleared), 0);
        check("reset aliveCount", 0, 32'(aliveCount), 0);
        check("reset busy", 0, 32'(busy), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Level 0, tick every cycle: first release two clocks after the pulse,
        // second release 20 ticks plus one clock later.
        genStim(1);
        computeReleases(0);
        endHit(2);
        runScenario(0, 1'b1, 0, '0, enCarry);
        check("l0 first release", 0, 32'(obsRel[0]), 32'd2);
        check("l0 spacing", 0, 32'(obsRel[1] - obsRel[0]), 32'd21);

        // Level 6: five releases spaced 14 ticks, nothing on bits 5..7.
        genStim(1);
        computeReleases(6);
        endHit(1);
        runScenario(6, 1'b1, 0, '0, enCarry);
        for (int k = 1; k < 5; k++) check("l6 spacing", k, 32'(obsRel[k] - obsRel[k-1]), 32'd15);
        for (int k = 5; k < NB; k++) check("l6 no release", k, 32'(obsRel[k]), 32'hFFFF_FFFF);

        // Level 15: full quota, minimum interval, everything hit at the end.
        genStim(3);
        computeReleases(15);
        endHit(1 + int'($urandom_range(4, 0)));
        runScenario(15, 1'b1, 0, '0, enCarry);

        // Level 4: biker2 hit before its slot, biker1 hit in its release cycle.
        genStim(2);
        computeReleases(4);
        hitArr[relCyc[2] - 2][2] = 1'b1;
        hitArr[relCyc[1]][1]     = 1'b1;
        endHit(3);
        runScenario(4, 1'b1, 0, '0, enCarry);
        check("l4 biker2 suppressed", 0, 32'(obsRel[2]), 32'hFFFF_FFFF);
        check("l4 biker1 suppressed", 0, 32'(obsRel[1]), 32'hFFFF_FFFF);
        check("l4 biker3 slot", 0, 32'(obsRel[3]), 32'(relCyc[3]));

        // Random levels, tick densities and stray hits.
        for (int r = 0; r < 4; r++) begin
            lvl = int'($urandom_range(15, 0));
            genStim(1 + int'($urandom_range(2, 0)));
            computeReleases(lvl);
            sparseHits(30);
            endHit(int'($urandom_range(6, 0)));
            runScenario(lvl, 1'b1, 0, '0, enCarry);
        end

        // Restart mid-WAIT with level 2; a coinciding hit is overridden.
        genStim(2);
        computeReleases(3);
        runScenario(3, 1'b1, relCyc[0] + 3, '0, enCarry);
        genStim(2);
        computeReleases(2);
        hitArr[0] = 8'(1 << $urandom_range(2, 0));
        endHit(2);
        runScenario(2, 1'b0, 0, enCarry, enCarry);

        // Reset in the middle of DRAIN: everything quiet, no levelCleared.
        genStim(1);
        computeReleases(15);
        runScenario(15, 1'b1, relCyc[qExp-1] + 3, '0, enCarry);
        @(posedge clk);
        #1;
        resetN       = 1'b0;
        startOfLevel = 1'b0;
        oneTensSec   = 1'b0;
        bikerHit     = '0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        check("drain reset enabled", 0, 32'(bikerEnabled), 0);
        check("drain reset startMovement", 0, 32'(bikerStartMovement), 0);
        check("drain reset aliveCount", 0, 32'(aliveCount), 0);
        check("drain reset busy", 0, 32'(busy), 0);
        check("drain reset levelCleared", 0, 32'(levelCleared), 0);
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            check("post reset levelCleared", c, 32'(levelCleared), 0);
            check("post reset busy", c, 32'(busy), 0);
        end

`ifdef SCHED_PAUSE_EN
        // Level 0 with 30 paused ticks inside the first WAIT.
        genStim(1);
        for (int c = 5; c < 35; c++) pauseArr[c] = 1'b1;
        computeReleases(0);
        endHit(2);
        runScenario(0, 1'b1, 0, '0, enCarry);
        check("pause spacing", 0, 32'(obsRel[1] - obsRel[0]), 32'd51);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
